bit_serializer: RTL and testbench

//   Parallel-to-serial front end for the serial sequence-detector path. Accepts

---
 rtl/bit_serializer.sv | 159 +++++++++++++++
 tb/tb_bit_serializer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end feeding the serial sequence detector.
// Words arrive over valid/ready and leave one bit at a time on sdata, gapless when back-to-back.
module bit_serializer #(
    parameter int DATA_W    = 8,
    parameter int DIV       = 1,
    parameter bit LSB_FIRST = 1'b0,
    parameter bit IDLE_LVL  = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              sdata,
    output logic              sbit_strobe,
    output logic              busy,
    output logic              frame_done
);

    localparam int BIT_W = $clog2(DATA_W);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [BIT_W-1:0] BIT_MAX  = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] BIT_ZERO = BIT_W'(0);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state_r;
    logic [DATA_W-1:0]   shreg_r;
    logic [BIT_W-1:0]    bit_cnt_r;
    logic [DIV_W-1:0]    div_cnt_r;
    logic                sdata_r;
    logic                strobe_r;
    logic                busy_r;
    logic                done_r;
    logic                ready_r;

    state_t              state_nxt_s;
    logic [DATA_W-1:0]   shreg_nxt_s;
    logic [BIT_W-1:0]    bit_cnt_nxt_s;
    logic [DIV_W-1:0]    div_cnt_nxt_s;
    logic                accept_s;
    logic                last_cyc_s;
    logic                last_nxt_s;
    logic                shift_nxt_s;

    // Bit currently presented on the serial line.
    function automatic logic out_bit(input logic [DATA_W-1:0] sr);
        logic b;
        if (LSB_FIRST) begin
            b = sr[0];
        end else begin
            b = sr[DATA_W-1];
        end
        return b;
    endfunction

    // Advance the shift register one place toward the output bit.
    function automatic logic [DATA_W-1:0] shift_once(input logic [DATA_W-1:0] sr);
        logic [DATA_W-1:0] r;
        if (LSB_FIRST) begin
            r = {1'b0, sr[DATA_W-1:1]};
        end else begin
            r = {sr[DATA_W-2:0], 1'b0};
        end
        return r;
    endfunction

    assign accept_s   = din_valid & ready_r;
    assign last_cyc_s = (state_r == SHIFT) & (bit_cnt_r == BIT_MAX) & (div_cnt_r == DIV_MAX);

    // Next-state datapath: load, shift, or reload on the final cycle of a word.
    always_comb begin
        state_nxt_s   = state_r;
        shreg_nxt_s   = shreg_r;
        bit_cnt_nxt_s = bit_cnt_r;
        div_cnt_nxt_s = div_cnt_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s   = SHIFT;
                    shreg_nxt_s   = din;
                    bit_cnt_nxt_s = BIT_ZERO;
                    div_cnt_nxt_s = DIV_ZERO;
                end else begin
                    state_nxt_s   = IDLE;
                end
            end
            SHIFT: begin
                if (last_cyc_s) begin
                    bit_cnt_nxt_s = BIT_ZERO;
                    div_cnt_nxt_s = DIV_ZERO;
                    if (accept_s) begin
                        // Reload straight away so the next word follows with no idle bit.
                        state_nxt_s = SHIFT;
                        shreg_nxt_s = din;
                    end else begin
                        state_nxt_s = IDLE;
                        shreg_nxt_s = shift_once(shreg_r);
                    end
                end else if (div_cnt_r == DIV_MAX) begin
                    div_cnt_nxt_s = DIV_ZERO;
                    shreg_nxt_s   = shift_once(shreg_r);
                    bit_cnt_nxt_s = bit_cnt_r + BIT_ONE;
                end else begin
                    div_cnt_nxt_s = div_cnt_r + DIV_ONE;
                end
            end
            default: begin
                state_nxt_s   = IDLE;
                shreg_nxt_s   = '0;
                bit_cnt_nxt_s = BIT_ZERO;
                div_cnt_nxt_s = DIV_ZERO;
            end
        endcase
    end

    assign shift_nxt_s = (state_nxt_s == SHIFT);
    assign last_nxt_s  = shift_nxt_s & (bit_cnt_nxt_s == BIT_MAX) & (div_cnt_nxt_s == DIV_MAX);

    // State and output flops; outputs are precomputed from next state so they leave straight from flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            shreg_r   <= '0;
            bit_cnt_r <= BIT_ZERO;
            div_cnt_r <= DIV_ZERO;
            sdata_r   <= IDLE_LVL;
            strobe_r  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            ready_r   <= 1'b1;
        end else begin
            state_r   <= state_nxt_s;
            shreg_r   <= shreg_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            div_cnt_r <= div_cnt_nxt_s;
            sdata_r   <= shift_nxt_s ? out_bit(shreg_nxt_s) : IDLE_LVL;
            strobe_r  <= shift_nxt_s & (div_cnt_nxt_s == DIV_ZERO);
            busy_r    <= shift_nxt_s;
            done_r    <= last_nxt_s;
            ready_r   <= ~shift_nxt_s | last_nxt_s;
        end
    end

    assign sdata       = sdata_r;
    assign sbit_strobe = strobe_r;
    assign busy        = busy_r;
    assign frame_done  = done_r;
    assign din_ready   = ready_r;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: three instances (MSB/DIV=1, DIV=3, LSB/IDLE_LVL=1) driven from a vector table,
// with a per-instance queue of expected per-cycle outputs filled on each accepted word.
module tb_bit_serializer;

    localparam int N = 3;

    typedef struct {
        logic sd;
        logic stb;
        logic done;
    } ent_t;

    typedef struct {
        int         inst;
        logic [7:0] word;
        logic [7:0] order;   // expected serial order, first bit at [7]
        bit         chain;   // keep din_valid high after accept (next vector follows)
        int         delay;   // cycles with din_valid low before presenting
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0][7:0] din;
    logic [N-1:0]      din_valid;
    wire  [N-1:0]      din_ready;
    wire  [N-1:0]      sdata;
    wire  [N-1:0]      sbit_strobe;
    wire  [N-1:0]      busy;
    wire  [N-1:0]      frame_done;

    ent_t       exp_q [N][$];
    logic [7:0] cur_order [N];
    logic [N-1:0] acc;
    vec_t       vecs [8];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bit_serializer #(.DATA_W(8), .DIV(1), .LSB_FIRST(1'b0), .IDLE_LVL(1'b0)) u_msb (
        .clk(clk), .reset(reset), .din(din[0]), .din_valid(din_valid[0]), .din_ready(din_ready[0]),
        .sdata(sdata[0]), .sbit_strobe(sbit_strobe[0]), .busy(busy[0]), .frame_done(frame_done[0]));

    bit_serializer #(.DATA_W(8), .DIV(3), .LSB_FIRST(1'b0), .IDLE_LVL(1'b0)) u_div3 (
        .clk(clk), .reset(reset), .din(din[1]), .din_valid(din_valid[1]), .din_ready(din_ready[1]),
        .sdata(sdata[1]), .sbit_strobe(sbit_strobe[1]), .busy(busy[1]), .frame_done(frame_done[1]));

    bit_serializer #(.DATA_W(8), .DIV(1), .LSB_FIRST(1'b1), .IDLE_LVL(1'b1)) u_lsb (
        .clk(clk), .reset(reset), .din(din[2]), .din_valid(din_valid[2]), .din_ready(din_ready[2]),
        .sdata(sdata[2]), .sbit_strobe(sbit_strobe[2]), .busy(busy[2]), .frame_done(frame_done[2]));

    function automatic int div_of(input int i);
        return (i == 1) ? 3 : 1;
    endfunction

    function automatic logic idle_of(input int i);
        return (i == 2) ? 1'b1 : 1'b0;
    endfunction

    task automatic chk(input string nm, input int i, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%b want=%b at t=%0t", nm, i, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        ent_t e;
        for (int i = 0; i < N; i++) begin
            if (exp_q[i].size() > 0) begin
                e = exp_q[i][0];
                chk("sdata", i, sdata[i], e.sd);
                chk("sbit_strobe", i, sbit_strobe[i], e.stb);
                chk("frame_done", i, frame_done[i], e.done);
                chk("busy", i, busy[i], 1'b1);
            end else begin
                chk("sdata_idle", i, sdata[i], idle_of(i));
                chk("sbit_strobe", i, sbit_strobe[i], 1'b0);
                chk("frame_done", i, frame_done[i], 1'b0);
                chk("busy", i, busy[i], 1'b0);
            end
            chk("din_ready", i, din_ready[i], exp_q[i].size() <= 1);
        end
    endtask

    task automatic push_word(input int i, input logic [7:0] order);
        int dv;
        dv = div_of(i);
        for (int b = 0; b < 8; b++) begin
            for (int d = 0; d < dv; d++) begin
                exp_q[i].push_back('{sd: order[7-b], stb: (d == 0), done: (b == 7 && d == dv - 1)});
            end
        end
    endtask

    // One clock: decide acceptance from the expected ready, advance the scoreboard, compare.
    task automatic tick();
        for (int i = 0; i < N; i++) begin
            acc[i] = din_valid[i] && (exp_q[i].size() <= 1);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (exp_q[i].size() > 0) begin
                void'(exp_q[i].pop_front());
            end
            if (acc[i]) begin
                push_word(i, cur_order[i]);
            end
        end
        check_outputs();
    endtask

    task automatic send(input vec_t v);
        int g;
        din[v.inst]       = v.word;
        cur_order[v.inst] = v.order;
        din_valid[v.inst] = 1'b1;
        g = 0;
        forever begin
            tick();
            g++;
            if (acc[v.inst]) break;
            if (g >= 64) begin
                total++;
                bad++;
                $display("FAIL accept_timeout[%0d] got=none want=accept within 64 cycles", v.inst);
                break;
            end
        end
    endtask

    task automatic drain(input int i);
        int g;
        g = 0;
        while (exp_q[i].size() > 0 && g < 100) begin
            tick();
            g++;
        end
        if (exp_q[i].size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout[%0d] got=%0d left want=0", i, exp_q[i].size());
        end
    endtask

    initial begin
        vec_t vr;
        din       = '0;
        din_valid = '0;
        acc       = '0;
        for (int i = 0; i < N; i++) cur_order[i] = 8'h00;

        vecs[0] = '{inst: 0, word: 8'b1000_1000, order: 8'b1000_1000, chain: 1'b0, delay: 0};
        vecs[1] = '{inst: 0, word: 8'hA5,        order: 8'hA5,        chain: 1'b1, delay: 0};
        vecs[2] = '{inst: 0, word: 8'h3C,        order: 8'h3C,        chain: 1'b0, delay: 0};
        vecs[3] = '{inst: 1, word: 8'hC0,        order: 8'hC0,        chain: 1'b0, delay: 2};
        vecs[4] = '{inst: 2, word: 8'b0000_0001, order: 8'b1000_0000, chain: 1'b0, delay: 1};
        vecs[5] = '{inst: 2, word: 8'hB4,        order: 8'h2D,        chain: 1'b0, delay: 0};
        vecs[6] = '{inst: 0, word: 8'h5A,        order: 8'h5A,        chain: 1'b1, delay: 1};
        vecs[7] = '{inst: 0, word: 8'hE7,        order: 8'hE7,        chain: 1'b0, delay: 3};

        // Reset state while reset is held.
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        reset = 1'b0;
        tick();

        for (int k = 0; k < 8; k++) begin
            for (int d = 0; d < vecs[k].delay; d++) begin
                din_valid[vecs[k].inst] = 1'b0;
                tick();
            end
            send(vecs[k]);
            if (!vecs[k].chain) begin
                din_valid[vecs[k].inst] = 1'b0;
                din[vecs[k].inst] = 8'($urandom);
                drain(vecs[k].inst);
            end
        end

        // din wiggling with din_valid low must not start a word.
        din_valid = '0;
        din[0] = 8'hFF;
        tick();
        din[0] = 8'h0F;
        tick();
        tick();

        // Reset mid-word at bit 4 of 8'hFF.
        vr = '{inst: 0, word: 8'hFF, order: 8'hFF, chain: 1'b0, delay: 0};
        send(vr);
        din_valid[0] = 1'b0;
        repeat (4) tick();
        #3;
        reset = 1'b1;
        #1;
        for (int i = 0; i < N; i++) exp_q[i].delete();
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        reset = 1'b0;
        repeat (10) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
